// File: rtl/serial_mod_checker.sv
// Serial divisibility checker: keeps the running remainder of a bit-serial binary
// number modulo DIVISOR (MSB- or LSB-first), with frame restart and a saturating bit count.
module serial_mod_checker #(
  parameter int unsigned  DIVISOR   = 5,
  parameter bit           MSB_FIRST = 1'b1,
  parameter int unsigned  CNT_W     = 8,
  localparam int unsigned RW        = (DIVISOR < 2) ? 1 : $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_bit,
  output logic [RW-1:0]    rem,
  output logic             div,
  output logic             out_valid,
  output logic [CNT_W-1:0] bit_cnt
);

  if ((DIVISOR < 2) || (DIVISOR > 255)) begin : g_bad_divisor
    $error("serial_mod_checker: DIVISOR must lie in 2..255");
  end

  localparam logic [RW+1:0]    DIV_EXT = (RW+2)'(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [RW-1:0]    rem_q, rem_d;
  logic [RW-1:0]    pow_q, pow_d;
  logic             div_q, div_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [RW-1:0]    r_base_s, p_base_s;
  logic [CNT_W-1:0] c_base_s;
  logic [RW+1:0]    rsum_s, psum_s;
  logic [RW-1:0]    rem_next_s, pow_next_s;

  // Next-state: frame base selection, single-subtract modular update, clear and stall handling.
  always_comb begin
    rem_d       = rem_q;
    pow_d       = pow_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;

    if (in_sof) begin
      r_base_s = {RW{1'b0}};
      p_base_s = RW'(1);
      c_base_s = {CNT_W{1'b0}};
    end else begin
      r_base_s = rem_q;
      p_base_s = pow_q;
      c_base_s = cnt_q;
    end

    // Operands are below DIVISOR, so each sum is below 2*DIVISOR and one subtract suffices.
    if (MSB_FIRST) begin
      rsum_s = {1'b0, r_base_s, in_bit};
    end else begin
      rsum_s = {2'b00, r_base_s} + (in_bit ? {2'b00, p_base_s} : {(RW+2){1'b0}});
    end
    psum_s     = {1'b0, p_base_s, 1'b0};
    rem_next_s = (rsum_s >= DIV_EXT) ? RW'(rsum_s - DIV_EXT) : RW'(rsum_s);
    pow_next_s = (psum_s >= DIV_EXT) ? RW'(psum_s - DIV_EXT) : RW'(psum_s);

    if (clr) begin
      rem_d       = {RW{1'b0}};
      pow_d       = RW'(1);
      cnt_d       = {CNT_W{1'b0}};
      out_valid_d = 1'b0;
    end else if (in_valid) begin
      rem_d       = rem_next_s;
      pow_d       = MSB_FIRST ? pow_q : pow_next_s;
      cnt_d       = (c_base_s == CNT_MAX) ? c_base_s : c_base_s + CNT_W'(1);
      out_valid_d = 1'b1;
    end else begin
      rem_d       = rem_q;
      pow_d       = pow_q;
      cnt_d       = cnt_q;
      out_valid_d = 1'b0;
    end

    div_d = (rem_d == {RW{1'b0}});
  end

  // State register with synchronous reset to the empty (divisible) number.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q       <= {RW{1'b0}};
      pow_q       <= RW'(1);
      div_q       <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      rem_q       <= rem_d;
      pow_q       <= pow_d;
      div_q       <= div_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rem       = rem_q;
  assign div       = div_q;
  assign out_valid = out_valid_q;
  assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_serial_mod_checker.sv
// Bench for serial_mod_checker: three configurations share one stimulus stream and are
// checked every cycle against an arithmetic model, plus hand-computed literal checks.
module tb_serial_mod_checker;

  logic clk;
  logic rst, clr, in_valid, in_sof, in_bit;

  logic [2:0] rem_a, rem_b;
  logic [1:0] rem_c;
  logic       div_a, div_b, div_c;
  logic       ov_a, ov_b, ov_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: the frame's number as a plain integer, its bit count and the count as the DUT saturates it.
  longint unsigned mval[3];
  int              mk[3];
  int              mcnt[3];
  bit              mov;
  int              md[3]    = '{5, 5, 3};
  bit              mmsb[3]  = '{1'b1, 1'b0, 1'b1};
  int              mcmax[3] = '{255, 255, 3};

  serial_mod_checker #(.DIVISOR(5), .MSB_FIRST(1'b1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_sof(in_sof), .in_bit(in_bit),
    .rem(rem_a), .div(div_a), .out_valid(ov_a), .bit_cnt(cnt_a));

  serial_mod_checker #(.DIVISOR(5), .MSB_FIRST(1'b0), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_sof(in_sof), .in_bit(in_bit),
    .rem(rem_b), .div(div_b), .out_valid(ov_b), .bit_cnt(cnt_b));

  serial_mod_checker #(.DIVISOR(3), .MSB_FIRST(1'b1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_sof(in_sof), .in_bit(in_bit),
    .rem(rem_c), .div(div_c), .out_valid(ov_c), .bit_cnt(cnt_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model on the edge, return at the next falling edge.
  task automatic step(input bit v, input bit sof, input bit b, input bit c, input bit r);
    in_valid = v; in_sof = sof; in_bit = b; clr = c; rst = r;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (r || c) begin
        mval[i] = 0; mk[i] = 0; mcnt[i] = 0;
      end else if (v) begin
        if (sof) begin
          mval[i] = 0; mk[i] = 0; mcnt[i] = 0;
        end
        if (mmsb[i]) mval[i] = mval[i] * 2 + longint'(b);
        else         mval[i] = mval[i] + (longint'(b) << mk[i]);
        mk[i]++;
        mcnt[i] = (mcnt[i] + 1 > mcmax[i]) ? mcmax[i] : mcnt[i] + 1;
      end
    end
    mov = v && !r && !c;
    @(negedge clk);
  endtask

  // Every-cycle comparison of all three DUTs against the model.
  initial begin
    int ar[3], ad[3], ao[3], ac[3], er;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        ar = '{int'(rem_a), int'(rem_b), int'(rem_c)};
        ad = '{int'(div_a), int'(div_b), int'(div_c)};
        ao = '{int'(ov_a), int'(ov_b), int'(ov_c)};
        ac = '{int'(cnt_a), int'(cnt_b), int'(cnt_c)};
        for (int i = 0; i < 3; i++) begin
          er = int'(mval[i] % longint'(md[i]));
          cmp($sformatf("model_rem[%0d]", i), ar[i], er);
          cmp($sformatf("model_div[%0d]", i), ad[i], (er == 0) ? 1 : 0);
          cmp($sformatf("model_ov[%0d]", i), ao[i], int'(mov));
          cmp($sformatf("model_cnt[%0d]", i), ac[i], mcnt[i]);
        end
      end
    end
  end

  initial begin
    in_valid = 1'b0; in_sof = 1'b0; in_bit = 1'b0; clr = 1'b0; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mval[i] = 0; mk[i] = 0; mcnt[i] = 0;
    end
    mov = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cmp("reset_rem", int'(rem_a), 0);
    cmp("reset_div", int'(div_a), 1);
    cmp("reset_ov", int'(ov_a), 0);
    cmp("reset_cnt", int'(cnt_a), 0);

    // 1,0,1,0 MSB-first mod 5
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); cmp("t1_rem0", int'(rem_a), 1); cmp("t1_div0", int'(div_a), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cmp("t1_rem1", int'(rem_a), 2);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); cmp("t1_rem2", int'(rem_a), 0); cmp("t1_div2", int'(div_a), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cmp("t1_rem3", int'(rem_a), 0); cmp("t1_div3", int'(div_a), 1);
    cmp("t1_cnt", int'(cnt_a), 4); cmp("t1_ov", int'(ov_a), 1); cmp("t1_lsb_rem", int'(rem_b), 0);

    // value 7 with a stall gap; a lone sof without valid must be ignored
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); cmp("t2_rem0", int'(rem_a), 1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); cmp("t2_rem1", int'(rem_a), 3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cmp("t2_gap_ov", int'(ov_a), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); cmp("t2_gap_rem", int'(rem_a), 3);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); cmp("t2_rem2", int'(rem_a), 2); cmp("t2_div2", int'(div_a), 0);
    cmp("t2_cnt", int'(cnt_a), 3);

    // 13 LSB-first mod 5
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); cmp("t3_rem0", int'(rem_b), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cmp("t3_rem1", int'(rem_b), 1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); cmp("t3_rem2", int'(rem_b), 0); cmp("t3_div2", int'(div_b), 1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); cmp("t3_rem3", int'(rem_b), 3); cmp("t3_div3", int'(div_b), 0);

    // 6 mod 3, then restart with sof
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); cmp("t4_rem0", int'(rem_c), 1); cmp("t4_cnt0", int'(cnt_c), 1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); cmp("t4_rem1", int'(rem_c), 0); cmp("t4_cnt1", int'(cnt_c), 2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cmp("t4_rem2", int'(rem_c), 0); cmp("t4_cnt2", int'(cnt_c), 3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); cmp("t4_rem3", int'(rem_c), 1); cmp("t4_cnt3", int'(cnt_c), 1);

    // mid-frame reset, then a bit without sof
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    cmp("t5_rem", int'(rem_a), 0); cmp("t5_div", int'(div_a), 1);
    cmp("t5_cnt", int'(cnt_a), 0); cmp("t5_ov", int'(ov_a), 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); cmp("t5_rem_after", int'(rem_a), 1);

    // clear with a valid bit, then 5 bits (1,0,1,1,0 = 22) into the 2-bit counter
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cmp("t6_clr_rem", int'(rem_a), 0); cmp("t6_clr_ov", int'(ov_a), 0); cmp("t6_clr_cnt", int'(cnt_a), 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("t6_sat_cnt", int'(cnt_c), 3); cmp("t6_sat_rem", int'(rem_c), 1);
    cmp("t6_rem5", int'(rem_a), 2); cmp("t6_cnt8", int'(cnt_a), 5);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1); cmp("t6_rst_clr_rem", int'(rem_a), 0);

    // mixed traffic, checked only by the per-cycle model comparison
    for (int n = 0; n < 80; n++) begin
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 7) == 0) || (mk[0] >= 40),
           1'($urandom_range(0, 1)),
           $urandom_range(0, 29) == 0,
           1'b0);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_mod_checker.md
Name: serial_mod_checker

Overview:
- Parametrised serial divisibility checker. Accepts a binary number one bit per accepted cycle and tracks its running remainder modulo DIVISOR.
- Flags divisibility after every accepted bit.
- Generalises the fixed divide-by-5 FSM:
  - configurable divisor,
  - MSB-first or LSB-first bit order,
  - valid qualification,
  - start-of-frame restart,
  - remainder and bit-count outputs.
- Sits behind serial receivers in the FSM library as a reusable checksum/divisibility monitor.

Parameters:
DIVISOR, 5, modulus; legal range 2..255
MSB_FIRST, 1, 1 = bits arrive MSB first; 0 = LSB first
CNT_W, 8, width of the accepted-bit counter
RW, $clog2(DIVISOR), remainder width (derived, not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
clr  input  1  synchronous frame clear, active-high
in_valid  input  1  in_bit is accepted this cycle when high
in_sof  input  1  qualified by in_valid; accepted bit is the first bit of a new number
in_bit  input  1  serial data bit
rem  output  RW  running value mod DIVISOR
div  output  1  high when rem == 0
out_valid  output  1  one-cycle pulse; rem/div just updated by an accepted bit
bit_cnt  output  CNT_W  bits accepted in current frame, saturating

Behaviour:
- All state is updated on the rising edge of clk. There are no asynchronous paths.
- Reset (rst=1) and clear (clr=1):
  - Both set rem=0, div=1, out_valid=0, bit_cnt=0, pow=1.
  - An empty number is 0, which counts as divisible.
  - rst has priority over clr. clr has priority over in_valid, so an accepted bit in the same cycle as clr is discarded.
- Internal pow register: width RW, holds 2^k mod DIVISOR. It is used only when MSB_FIRST=0; it can be removed by generate when MSB_FIRST=1.
- Accept rule: a bit is accepted when in_valid=1 and neither rst nor clr is asserted.
- Base values for each accepted bit:
  - If in_sof=1: r_base=0, p_base=1, c_base=0.
  - Otherwise: r_base=rem, p_base=pow, c_base=bit_cnt.
- MSB_FIRST=1 update:
  - rem <= (2*r_base + in_bit) mod DIVISOR.
  - Compute at width RW+2; the reduction needs at most one conditional subtract, since 2*r_base+1 < 2*DIVISOR.
- MSB_FIRST=0 update:
  - rem <= (r_base + (in_bit ? p_base : 0)) mod DIVISOR, one conditional subtract.
  - pow <= (2*p_base) mod DIVISOR, one conditional subtract.
- Counter: bit_cnt <= c_base+1, saturating at 2^CNT_W-1. Saturation does not affect rem/div.
- div: a registered copy of (next rem == 0), so div and rem always agree.
- Latency: rem, div, bit_cnt and out_valid change on the edge that accepts the bit, and are visible the following cycle. out_valid=1 exactly in the cycle after each accepted bit.
- Stalls: when in_valid=0, rem, div, pow and bit_cnt hold, and out_valid=0.
- Back-to-back bits: a new bit can be accepted every cycle, with no bubbles.
- in_sof with in_valid=0 is ignored.
- in_sof on the very first bit after reset gives the same result as leaving it low.
- Reset or clear in mid-frame drops the partial number. The next accepted bit starts from 0 whether or not in_sof is set.
- DIVISOR outside 2..255 must be rejected at elaboration with an $error in a generate check.

Test Plan:
1. DIVISOR=5, MSB_FIRST=1, bits 1,0,1,0 back-to-back (sof on first) -> rem 1,2,0,0; div 0,0,1,1; out_valid high 4 cycles; bit_cnt=4.
2. DIVISOR=5, MSB_FIRST=1, bits 1,1,1 (value 7), with in_valid low 3 cycles between bits 2 and 3 -> rem 1,3 held through gap, then 2; div=0; out_valid only after accepted bits.
3. DIVISOR=5, MSB_FIRST=0, value 13 LSB-first: bits 1,0,1,1 -> pow 2,4,3,1; rem 1,1,0,3; div pulses high after bit 3 only.
4. DIVISOR=3, MSB_FIRST=1, bits 1,1,0 (value 6) then in_sof with bit 1 -> rem 1,0,0 then 1; bit_cnt 1,2,3 then 1.
5. DIVISOR=5, mid-frame rst after bits 1,1 -> next cycle rem=0, div=1, bit_cnt=0, out_valid=0. Next bit 1 without sof gives rem=1.
6. clr and in_valid=1 in the same cycle -> bit discarded, rem=0, out_valid=0 next cycle. With CNT_W=2, feeding 5 bits leaves bit_cnt saturated at 3 and rem still correct.
